prio_enc_debounce: RTL and testbench

Debounced 8-to-3 priority encoder that feeds the seven-segment digit decoder. It takes eight raw, asynchronous switch inputs and synchronises them. It then accepts a new switch pattern only after the pattern has held stable for a programmable number of cycles. The index of the highest set bit drives the decoder's `data`, and the "any bit set" flag drives its `en`.

---
 rtl/prio_enc_debounce.sv | 92 +++++++++
 tb/tb_prio_enc_debounce.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_debounce.sv
// Debounced 8-to-3 priority encoder feeding the seven-segment decoder (data/en).
// Latency: DB_CYCLES+4 edges from a switch change to data/valid; 1 edge from en_in.
// Backpressure: none; outputs are registered every edge and update pulses per change.
module prio_enc_debounce #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_in,
    input  logic [7:0] sw,
    output logic [2:0] data,
    output logic       valid,
    output logic       update
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    typedef enum logic {
        SETTLING,
        COUNTING
    } phase_t;

    phase_t           phase;
    logic [7:0]       s1, s2;
    logic [7:0]       cand, cand_nxt;
    logic [7:0]       stable, stable_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       enc;
    logic             any;
    logic             valid_nxt;
    logic [2:0]       data_nxt;

    // The phase is implied by whether the synchronised input still matches the candidate.
    assign phase = (s2 != cand) ? SETTLING : COUNTING;

    always_comb begin
        cand_nxt   = cand;
        cnt_nxt    = cnt;
        stable_nxt = stable;
        case (phase)
            SETTLING: begin
                cand_nxt = s2;
                cnt_nxt  = '0;
            end
            COUNTING: begin
                if (cnt < CNT_MAX) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end else begin
                    stable_nxt = cand;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        enc = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (stable[i]) begin
                enc = 3'(i);
            end
        end
    end

    assign any       = |stable;
    assign valid_nxt = en_in & any;
    assign data_nxt  = any ? enc : 3'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
            data   <= 3'd0;
            valid  <= 1'b0;
            update <= 1'b0;
        end else begin
            s1     <= sw;
            s2     <= s1;
            cand   <= cand_nxt;
            cnt    <= cnt_nxt;
            stable <= stable_nxt;
            data   <= data_nxt;
            valid  <= valid_nxt;
            update <= ({valid_nxt, data_nxt} != {valid, data});
        end
    end

endmodule

// File: tb/tb_prio_enc_debounce.sv
// Bench for prio_enc_debounce: directed scenarios plus randomized switch traffic
// checked against a sliding-window model of the debounce rule.
module tb_prio_enc_debounce;

    localparam int DB = 16;
    localparam int HL = DB + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_in;
    logic [7:0] sw;
    logic [2:0] data;
    logic       valid;
    logic       update;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: raw switch samples at each edge and the expected outputs.
    logic [7:0] hist[$];
    logic [7:0] m_stable;
    logic       m_valid;
    logic [2:0] m_data;
    logic       m_update;

    always #5 clk = ~clk;

    prio_enc_debounce #(.DB_CYCLES(DB)) dut (
        .clk    (clk),
        .rst    (rst),
        .en_in  (en_in),
        .sw     (sw),
        .data   (data),
        .valid  (valid),
        .update (update)
    );

    function automatic logic [2:0] top_bit(input logic [7:0] p);
        for (int i = 7; i >= 0; i--) begin
            if (p[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < HL; i++) hist.push_back(8'h00);
        m_stable = 8'h00;
        m_valid  = 1'b0;
        m_data   = 3'd0;
        m_update = 1'b0;
    endtask

    // A pattern is accepted once DB+1 consecutive raw samples agree; the two newest
    // samples are still inside the synchroniser and do not count yet.
    task automatic tick();
        logic       nv;
        logic [2:0] nd;
        logic       same;
        @(posedge clk);
        hist.push_back(sw);
        void'(hist.pop_front());
        nv       = en_in && (m_stable != 8'h00);
        nd       = top_bit(m_stable);
        m_update = ({nv, nd} != {m_valid, m_data});
        m_valid  = nv;
        m_data   = nd;
        same = 1'b1;
        for (int i = 1; i <= DB; i++) begin
            if (hist[i] != hist[0]) same = 1'b0;
        end
        if (same) m_stable = hist[0];
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        en_in = 1'b0;
        sw    = 8'h00;
        model_reset();
        @(negedge clk);
        tests_run++;
        if ({valid, data, update} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%0b d=%0d u=%0b want all 0", valid, data, update);
        end
        en_in = 1'b1;
        rst   = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            tests_run++;
            if ({valid, data, update} !== 5'b0) begin
                tests_failed++;
                $display("FAIL reset_idle cyc %0d: got v=%0b d=%0d u=%0b want all 0", i, valid, data, update);
            end
        end
    endtask

    task automatic test_single_bit();
        sw = 8'b0000_0100;
        for (int i = 1; i <= 22; i++) begin
            tick();
            tests_run++;
            if ({valid, data, update} !== {m_valid, m_data, m_update}) begin
                tests_failed++;
                $display("FAIL single_model cyc %0d: got v=%0b d=%0d u=%0b want v=%0b d=%0d u=%0b",
                         i, valid, data, update, m_valid, m_data, m_update);
            end
            if (i < 20 || i >= 20) begin
                tests_run++;
                if ((i < 20 && {valid, data, update} !== 5'b0) ||
                    (i == 20 && {valid, data, update} !== {1'b1, 3'd2, 1'b1}) ||
                    (i > 20 && {valid, data, update} !== {1'b1, 3'd2, 1'b0})) begin
                    tests_failed++;
                    $display("FAIL single_latency cyc %0d: got v=%0b d=%0d u=%0b", i, valid, data, update);
                end
            end
        end
    endtask

    task automatic test_priority();
        sw = 8'b1010_0001;
        for (int i = 1; i <= 24; i++) begin
            tick();
            tests_run++;
            if ({valid, data, update} !== {m_valid, m_data, m_update}) begin
                tests_failed++;
                $display("FAIL prio_model cyc %0d: got v=%0b d=%0d u=%0b want v=%0b d=%0d u=%0b",
                         i, valid, data, update, m_valid, m_data, m_update);
            end
        end
        tests_run++;
        if ({valid, data} !== {1'b1, 3'd7}) begin
            tests_failed++;
            $display("FAIL prio_a1: got v=%0b d=%0d want v=1 d=7", valid, data);
        end
        sw = 8'b0010_0001;
        for (int i = 1; i <= 21; i++) begin
            tick();
            if (i == 19 || i == 20) begin
                tests_run++;
                if ((i == 19 && {valid, data, update} !== {1'b1, 3'd7, 1'b0}) ||
                    (i == 20 && {valid, data, update} !== {1'b1, 3'd5, 1'b1})) begin
                    tests_failed++;
                    $display("FAIL prio_21 cyc %0d: got v=%0b d=%0d u=%0b", i, valid, data, update);
                end
            end
        end
    endtask

    task automatic test_glitch();
        sw = 8'h00;
        for (int i = 1; i <= 24; i++) tick();
        tests_run++;
        if ({valid, data} !== {1'b0, 3'd0}) begin
            tests_failed++;
            $display("FAIL glitch_idle: got v=%0b d=%0d want v=0 d=0", valid, data);
        end
        for (int i = 1; i <= 40; i++) begin
            sw = (i <= 10) ? 8'h80 : 8'h00;
            tick();
            tests_run++;
            if ({valid, data, update} !== 5'b0 || m_update !== 1'b0) begin
                tests_failed++;
                $display("FAIL glitch_short cyc %0d: got v=%0b d=%0d u=%0b model_u=%0b want all 0",
                         i, valid, data, update, m_update);
            end
        end
        sw = 8'h80;
        for (int i = 1; i <= 24; i++) begin
            tick();
            tests_run++;
            if ({valid, data, update} !== {m_valid, m_data, m_update}) begin
                tests_failed++;
                $display("FAIL glitch_long cyc %0d: got v=%0b d=%0d u=%0b want v=%0b d=%0d u=%0b",
                         i, valid, data, update, m_valid, m_data, m_update);
            end
        end
        tests_run++;
        if ({valid, data} !== {1'b1, 3'd7}) begin
            tests_failed++;
            $display("FAIL glitch_accept: got v=%0b d=%0d want v=1 d=7", valid, data);
        end
    endtask

    task automatic test_en_toggle();
        logic [4:0] exp_seq [4];
        sw = 8'h08;
        for (int i = 1; i <= 24; i++) tick();
        tests_run++;
        if ({valid, data} !== {1'b1, 3'd3}) begin
            tests_failed++;
            $display("FAIL en_setup: got v=%0b d=%0d want v=1 d=3", valid, data);
        end
        exp_seq[0] = {1'b0, 3'd3, 1'b1};
        exp_seq[1] = {1'b0, 3'd3, 1'b0};
        exp_seq[2] = {1'b1, 3'd3, 1'b1};
        exp_seq[3] = {1'b1, 3'd3, 1'b0};
        for (int i = 0; i < 4; i++) begin
            en_in = (i >= 2);
            tick();
            tests_run++;
            if ({valid, data, update} !== exp_seq[i] ||
                {valid, data, update} !== {m_valid, m_data, m_update}) begin
                tests_failed++;
                $display("FAIL en_toggle step %0d: got v=%0b d=%0d u=%0b want %b",
                         i, valid, data, update, exp_seq[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 6; i++) begin
            en_in = ~en_in;
            tick();
            tests_run++;
            if (update !== 1'b1 || valid !== en_in || data !== 3'd3) begin
                tests_failed++;
                $display("FAIL b2b_pulse %0d: got v=%0b d=%0d u=%0b want v=%0b d=3 u=1",
                         i, valid, data, update, en_in);
            end
        end
        en_in = 1'b1;
        tick();
        sw = 8'h40;
        for (int i = 1; i <= 21; i++) begin
            if (i == 20) en_in = 1'b0;
            tick();
            if (i >= 19) begin
                tests_run++;
                if ((i == 19 && {valid, data, update} !== {1'b1, 3'd3, 1'b0}) ||
                    (i == 20 && {valid, data, update} !== {1'b0, 3'd6, 1'b1}) ||
                    (i == 21 && {valid, data, update} !== {1'b0, 3'd6, 1'b0})) begin
                    tests_failed++;
                    $display("FAIL simul_en_accept cyc %0d: got v=%0b d=%0d u=%0b", i, valid, data, update);
                end
            end
        end
        en_in = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        sw = 8'h10;
        for (int i = 1; i <= 12; i++) tick();
        tests_run++;
        if ({valid, data} !== {1'b1, 3'd6}) begin
            tests_failed++;
            $display("FAIL midrst_pre: got v=%0b d=%0d want v=1 d=6", valid, data);
        end
        rst = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if ({valid, data, update} !== 5'b0) begin
            tests_failed++;
            $display("FAIL midrst_async: got v=%0b d=%0d u=%0b want all 0", valid, data, update);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 22; i++) begin
            tick();
            tests_run++;
            if ((i < 20 && {valid, data, update} !== 5'b0) ||
                (i == 20 && {valid, data, update} !== {1'b1, 3'd4, 1'b1}) ||
                (i > 20 && {valid, data, update} !== {1'b1, 3'd4, 1'b0})) begin
                tests_failed++;
                $display("FAIL midrst_recover cyc %0d: got v=%0b d=%0d u=%0b", i, valid, data, update);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        for (int seg = 0; seg < 40; seg++) begin
            sw   = 8'($urandom) & 8'($urandom);
            hold = $urandom_range(1, 24);
            for (int i = 0; i < hold; i++) begin
                if ($urandom_range(0, 9) == 0) en_in = ~en_in;
                tick();
                tests_run++;
                if ({valid, data, update} !== {m_valid, m_data, m_update}) begin
                    tests_failed++;
                    $display("FAIL random seg %0d cyc %0d: got v=%0b d=%0d u=%0b want v=%0b d=%0d u=%0b",
                             seg, i, valid, data, update, m_valid, m_data, m_update);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_priority();
        test_glitch();
        test_en_toggle();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
